// File: rtl/prog_ram_if.sv
// prog_ram_if: CPU bus and program-loader signals for prog_ram.
// master: CPU/loader side. slave: the RAM.
interface prog_ram_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] addr;
    logic              write;
    logic              read;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              data_out_en;
    logic              prog_mode;
    logic              prog_valid;
    logic [DATA_W-1:0] prog_data;
    logic              prog_ready;
    logic              prog_done;
    logic [ADDR_W:0]   prog_count;
    logic              busy;

    modport master (
        output addr, write, read, data_in, prog_mode, prog_valid, prog_data,
        input  data_out, data_out_en, prog_ready, prog_done, prog_count, busy
    );

    modport slave (
        input  addr, write, read, data_in, prog_mode, prog_valid, prog_data,
        output data_out, data_out_en, prog_ready, prog_done, prog_count, busy
    );
endinterface

// File: rtl/prog_ram.sv
// prog_ram: 2**ADDR_W x DATA_W main memory with combinational CPU read,
// clocked CPU write and a valid/ready program-load port with an
// auto-incrementing address counter.
// Optional macro RAM_CLEAR_ON_RESET_EN: reset sweeps the memory to zero
// (CLEAR state, one word per cycle) before returning to RUN.
module prog_ram #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input logic        clk,
    input logic        rst,
    prog_ram_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_PROG  = 2'd1
`ifdef RAM_CLEAR_ON_RESET_EN
        ,
        ST_CLEAR = 2'd2
`endif
    } state_t;

    state_t            state;
    logic [ADDR_W:0]   count;
`ifdef RAM_CLEAR_ON_RESET_EN
    logic [ADDR_W-1:0] clr_idx;
`endif

    logic [DATA_W-1:0] mem [DEPTH];

    logic              ready;
    logic              handshake;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;

    // Handshake qualifiers depend only on registered state, never on prog_valid.
    always_comb begin
        ready     = (state == ST_PROG) && (count < DEPTH_CNT);
        handshake = ready && bus.prog_valid;
    end

    // Mode sequencing and load counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            count   <= '0;
`ifdef RAM_CLEAR_ON_RESET_EN
            state   <= ST_CLEAR;
            clr_idx <= '0;
`else
            state   <= ST_RUN;
`endif
        end else begin
            case (state)
                ST_RUN: begin
                    if (bus.prog_mode) begin
                        state <= ST_PROG;
                        count <= '0;
                    end
                end
                ST_PROG: begin
                    if (handshake)
                        count <= count + 1'b1;
                    if (!bus.prog_mode)
                        state <= ST_RUN;
                end
`ifdef RAM_CLEAR_ON_RESET_EN
                ST_CLEAR: begin
                    clr_idx <= clr_idx + 1'b1;
                    if (clr_idx == '1)
                        state <= ST_RUN;
                end
`endif
                default: state <= ST_RUN;
            endcase
        end
    end

    // Single write port, source selected by mode; no writes while rst is held.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = bus.addr;
        wr_data = bus.data_in;
        if (!rst) begin
            case (state)
                ST_RUN: begin
                    wr_en = bus.write;
                end
                ST_PROG: begin
                    wr_en   = handshake;
                    wr_addr = count[ADDR_W-1:0];
                    wr_data = bus.prog_data;
                end
`ifdef RAM_CLEAR_ON_RESET_EN
                ST_CLEAR: begin
                    wr_en   = 1'b1;
                    wr_addr = clr_idx;
                    wr_data = '0;
                end
`endif
                default: wr_en = 1'b0;
            endcase
        end
    end

    // Storage array; read is asynchronous so a same-cycle write shows next cycle.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
    end

    // CPU read path and status outputs.
    always_comb begin
        rd_en           = (state == ST_RUN) && bus.read;
        bus.data_out    = rd_en ? mem[bus.addr] : '0;
        bus.data_out_en = rd_en;
        bus.prog_ready  = ready;
        bus.prog_done   = (count == DEPTH_CNT);
        bus.prog_count  = count;
        bus.busy        = (state != ST_RUN);
    end
endmodule

// File: tb/tb_prog_ram.sv
// tb_prog_ram: directed test-plan steps plus a randomized phase, all
// checked every cycle against a behavioural model of the RAM.
module tb_prog_ram;
    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    prog_ram_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    prog_ram #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Behavioural model
    logic [7:0] m_mem [DEPTH];
    bit         m_prog     = 1'b0;
    int         m_cnt      = 0;
    int         m_clr_left = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs();
        bit busy_e;
        bit rd_e;
        busy_e = m_prog || (m_clr_left > 0);
        rd_e   = !busy_e && bus.read;
        chk("busy", bus.busy, busy_e);
        chk("data_out_en", bus.data_out_en, rd_e);
        chk("data_out", bus.data_out, rd_e ? m_mem[bus.addr] : 8'h00);
        chk("prog_ready", bus.prog_ready, m_prog && (m_cnt < DEPTH));
        chk("prog_done", bus.prog_done, m_cnt == DEPTH);
        chk("prog_count", bus.prog_count, m_cnt);
    endtask

    // Apply the effect of one rising edge given the inputs currently driven.
    task automatic model_edge();
        if (rst) begin
            m_prog = 1'b0;
            m_cnt  = 0;
`ifdef RAM_CLEAR_ON_RESET_EN
            m_clr_left = DEPTH;
`endif
        end else if (m_clr_left > 0) begin
            m_mem[DEPTH - m_clr_left] = 8'h00;
            m_clr_left--;
        end else if (!m_prog) begin
            if (bus.write)
                m_mem[bus.addr] = bus.data_in;
            if (bus.prog_mode) begin
                m_prog = 1'b1;
                m_cnt  = 0;
            end
        end else begin
            if (bus.prog_valid && m_cnt < DEPTH) begin
                m_mem[m_cnt] = bus.prog_data;
                m_cnt++;
            end
            if (!bus.prog_mode)
                m_prog = 1'b0;
        end
    endtask

    task automatic cyc();
        #2;
        check_outputs();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int k;
        int c;
        int n;

        rst            = 1'b1;
        bus.addr       = '0;
        bus.write      = 1'b0;
        bus.read       = 1'b0;
        bus.data_in    = '0;
        bus.prog_mode  = 1'b0;
        bus.prog_valid = 1'b0;
        bus.prog_data  = '0;
        #2;
        model_edge();
        @(posedge clk);
        #1;

        // Reset state
        #1;
`ifdef RAM_CLEAR_ON_RESET_EN
        chk("rst_busy", bus.busy, 1'b1);
`else
        chk("rst_busy", bus.busy, 1'b0);
`endif
        chk("rst_count", bus.prog_count, 0);
        chk("rst_ready", bus.prog_ready, 1'b0);
        chk("rst_done", bus.prog_done, 1'b0);
        cyc();
        rst = 1'b0;
`ifdef RAM_CLEAR_ON_RESET_EN
        repeat (DEPTH) cyc();
`endif

        // Preload with random contents
        for (int i = 0; i < DEPTH; i++) begin
            bus.addr    = 4'(i);
            bus.data_in = 8'($urandom);
            bus.write   = 1'b1;
            cyc();
        end
        bus.write = 1'b0;

        // 1: write then read
        bus.addr    = 4'h3;
        bus.data_in = 8'hA5;
        bus.write   = 1'b1;
        cyc();
        bus.write = 1'b0;
        bus.read  = 1'b1;
        #2;
        chk("t1_rd_data", bus.data_out, 8'hA5);
        chk("t1_rd_en", bus.data_out_en, 1'b1);
        cyc();
        bus.read = 1'b0;
        #2;
        chk("t1_idle_data", bus.data_out, 8'h00);
        chk("t1_idle_en", bus.data_out_en, 1'b0);
        cyc();

        // 2: same-cycle read/write at one address
        bus.addr    = 4'h5;
        bus.data_in = 8'h11;
        bus.write   = 1'b1;
        cyc();
        bus.read    = 1'b1;
        bus.data_in = 8'h22;
        #2;
        chk("t2_old", bus.data_out, 8'h11);
        cyc();
        bus.write = 1'b0;
        #2;
        chk("t2_new", bus.data_out, 8'h22);
        cyc();
        bus.read = 1'b0;

        // 3: full load with valid stalled every third cycle
        bus.prog_mode = 1'b1;
        cyc();
        k = 0;
        c = 0;
        while (k < DEPTH && c < 100) begin
            bus.prog_valid = (c % 3) != 2;
            bus.prog_data  = 8'(8'h10 + k);
            if (bus.prog_valid)
                k++;
            cyc();
            c++;
        end
        bus.prog_valid = 1'b0;
        chk("t3_load_words", k, DEPTH);
        #2;
        chk("t3_count", bus.prog_count, 16);
        chk("t3_done", bus.prog_done, 1'b1);
        chk("t3_ready", bus.prog_ready, 1'b0);
        bus.prog_valid = 1'b1;
        bus.prog_data  = 8'hEE;
        cyc();
        bus.prog_valid = 1'b0;
        bus.prog_mode  = 1'b0;
        cyc();
        chk("t3_busy", bus.busy, 1'b0);
        bus.read = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            bus.addr = 4'(i);
            #2;
            chk("t3_mem", bus.data_out, 8'h10 + i);
            cyc();
        end
        bus.read = 1'b0;

        // 4: partial load, leave PROG on the 5th handshake
        bus.prog_mode = 1'b1;
        cyc();
        for (int j = 0; j < 5; j++) begin
            bus.prog_valid = 1'b1;
            bus.prog_data  = 8'(8'h40 + j);
            if (j == 4)
                bus.prog_mode = 1'b0;
            cyc();
        end
        bus.prog_valid = 1'b0;
        #2;
        chk("t4_busy", bus.busy, 1'b0);
        chk("t4_count", bus.prog_count, 5);
        bus.addr = 4'h4;
        bus.read = 1'b1;
        #1;
        chk("t4_mem4", bus.data_out, 8'h44);
        cyc();
        bus.read = 1'b0;

`ifndef RAM_CLEAR_ON_RESET_EN
        // 5: reset mid-PROG keeps written words
        bus.prog_mode = 1'b1;
        cyc();
        for (int j = 0; j < 3; j++) begin
            bus.prog_valid = 1'b1;
            bus.prog_data  = 8'(8'h60 + j);
            cyc();
        end
        bus.prog_valid = 1'b0;
        bus.prog_mode  = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #2;
        chk("t5_count", bus.prog_count, 0);
        chk("t5_busy", bus.busy, 1'b0);
        bus.read = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.addr = 4'(i);
            #1;
            chk("t5_kept", bus.data_out, 8'h60 + i);
            cyc();
        end
        bus.read      = 1'b0;
        bus.prog_mode = 1'b1;
        cyc();
        bus.prog_valid = 1'b1;
        bus.prog_data  = 8'h77;
        cyc();
        bus.prog_valid = 1'b0;
        bus.prog_mode  = 1'b0;
        cyc();
        bus.read = 1'b1;
        bus.addr = 4'h0;
        #1;
        chk("t5_resume0", bus.data_out, 8'h77);
        cyc();
        bus.addr = 4'h1;
        #1;
        chk("t5_keep1", bus.data_out, 8'h61);
        cyc();
        bus.read = 1'b0;
`else
        // 6: clear sweep on reset, and restart of the sweep
        for (int i = 0; i < DEPTH; i++) begin
            bus.addr    = 4'(i);
            bus.data_in = 8'hFF;
            bus.write   = 1'b1;
            cyc();
        end
        bus.write = 1'b0;
        rst = 1'b1;
        cyc();
        rst         = 1'b0;
        bus.write   = 1'b1;
        bus.data_in = 8'hAB;
        n = 0;
        while (bus.busy && n < 40) begin
            bus.addr = 4'(n);
            cyc();
            n++;
        end
        bus.write = 1'b0;
        chk("t6_busy_cycles", n, 16);
        bus.read = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            bus.addr = 4'(i);
            #1;
            chk("t6_cleared", bus.data_out, 8'h00);
            cyc();
        end
        bus.read = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        repeat (7) cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        n = 0;
        while (bus.busy && n < 40) begin
            cyc();
            n++;
        end
        chk("t6_restart_cycles", n, 16);
`endif

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            rst            = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 7) == 0)
                bus.prog_mode = ~bus.prog_mode;
            bus.prog_valid = 1'($urandom);
            bus.prog_data  = 8'($urandom);
            bus.addr       = 4'($urandom);
            bus.data_in    = 8'($urandom);
            bus.read       = 1'($urandom);
            bus.write      = 1'($urandom);
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
